// File: rtl/mdl_satatx_arb.sv
// Device-to-host frame arbiter for the SATA bench model: frame-atomic round-robin grants,
// forced idle gap, MAXLEN truncation with m_abort. Optional macro MDL_TXARB_PRIO_EN: req 0 strict priority.
module mdl_satatx_arb #(
  parameter int NREQ   = 3,
  parameter int DW     = 32,
  parameter int MAXLEN = 2049,
  parameter int GAP    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NREQ-1:0]      s_valid,
  output logic [NREQ-1:0]      s_ready,
  input  logic [NREQ*DW-1:0]   s_data,
  input  logic [NREQ-1:0]      s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DW-1:0]        m_data,
  output logic                 m_last,
  output logic                 m_abort,
  output logic [NREQ-1:0]      o_grant,
  output logic                 o_busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXLEN + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DRAIN, ST_GAP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic [IW-1:0]   cand, win_idx;
  logic            win_found;
  logic            g_valid, g_last, at_max, frame_end;
  logic [DW-1:0]   g_data;

  // Round-robin search starting one past the last owner.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(rr_q) + i) % NREQ);
      if (!win_found && s_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef MDL_TXARB_PRIO_EN
    if (s_valid[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`else
`endif
  end

  assign g_valid = s_valid[gidx_q];
  assign g_last  = s_last[gidx_q];
  assign g_data  = s_data[gidx_q*DW +: DW];
  assign at_max  = (cnt_q == CW'(MAXLEN - 1));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    frame_end = 1'b0;
    s_ready   = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_last    = 1'b0;
    m_abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d          = ST_XFER;
          gidx_d           = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      ST_XFER: begin
        m_valid         = g_valid;
        m_data          = g_data;
        // s_last on the MAXLEN-th word is a clean end, not a truncation.
        m_last          = g_last | (g_valid & at_max);
        m_abort         = g_valid & at_max & ~g_last;
        s_ready[gidx_q] = m_ready;
        if (g_valid && m_ready) begin
          if (g_last)               frame_end = 1'b1;
          else if (at_max)          state_d   = ST_DRAIN;
          else if (cnt_q != '1)     cnt_d     = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        s_ready[gidx_q] = 1'b1;
        if (g_valid && g_last) frame_end = 1'b1;
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_end) begin
      grant_d = '0;
      cnt_d   = '0;
      gap_d   = '0;
      rr_d    = gidx_q;
      state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= IW'(NREQ - 1);
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q != ST_IDLE);

endmodule
